// File: rtl/mem_arb.sv
// mem_arb: shares the single-port data memory between the CPU M-stage and a loader port,
// with CPU priority, a starvation guard for the loader and a loader burst lock.
module mem_arb #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_SELECT   = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_c_req,
    input  logic                  i_c_we,
    input  logic [MEM_SELECT-1:0] i_c_addr,
    input  logic [DATA_WIDTH-1:0] i_c_wdata,
    output logic                  o_c_gnt,
    output logic                  o_c_stall,
    output logic [DATA_WIDTH-1:0] o_c_rdata,
    input  logic                  i_l_req,
    input  logic                  i_l_we,
    input  logic                  i_l_lock,
    input  logic [MEM_SELECT-1:0] i_l_addr,
    input  logic [DATA_WIDTH-1:0] i_l_wdata,
    output logic                  o_l_gnt,
    output logic                  o_l_rvalid,
    output logic [DATA_WIDTH-1:0] o_l_rdata,
    output logic                  o_mem_we,
    output logic [MEM_SELECT-1:0] o_mem_sel,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CPU  = 2'd1;
    localparam logic [1:0] LDR  = 2'd2;
    localparam logic [1:0] LOCK = 2'd3;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          l_pick;

    assign starved = starve_cnt == CW'(STARVE_LIMIT);
    // Loader wins while locked, when starved, or whenever the CPU is idle.
    assign l_pick    = state == LOCK || (starved && i_l_req) || (!i_c_req && i_l_req);
    assign o_l_gnt   = !rst && l_pick;
    assign o_c_gnt   = !rst && !l_pick && i_c_req;
    assign o_c_stall = !rst && i_c_req && !o_c_gnt;

    assign o_mem_we    = (o_l_gnt && i_l_req && i_l_we) || (o_c_gnt && i_c_we);
    assign o_mem_sel   = o_l_gnt ? i_l_addr  : o_c_gnt ? i_c_addr  : '0;
    assign o_mem_wdata = o_l_gnt ? i_l_wdata : o_c_gnt ? i_c_wdata : '0;
    assign o_c_rdata   = o_c_gnt ? i_mem_rdata : '0;

    always_comb begin
        state_nxt = IDLE;
        if (o_l_gnt)
            state_nxt = (i_l_lock && i_l_req) ? LOCK : LDR;
        else if (o_c_gnt)
            state_nxt = CPU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            o_l_rvalid <= 1'b0;
            o_l_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= (!i_l_req || o_l_gnt) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
            o_l_rvalid <= o_l_gnt && i_l_req && !i_l_we;
            if (o_l_gnt && i_l_req && !i_l_we)
                o_l_rdata <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vectors against mem_arb with a small behavioural memory behind it.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_stall;
    logic [2:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [2:0]  l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic        mem_we;
    logic [2:0]  mem_sel;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [8];
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    mem_arb #(.DATA_WIDTH(32), .MEM_SELECT(3), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt), .o_c_stall(c_stall), .o_c_rdata(c_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_lock(l_lock), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
        .o_mem_we(mem_we), .o_mem_sel(mem_sel), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_sel];
    always @(posedge clk) if (mem_we) mem[mem_sel] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [2:0] a, input logic [31:0] d);
        c_req = req; c_we = we; c_addr = a; c_wdata = d;
    endtask

    task automatic ldr(input logic req, input logic we, input logic lk, input logic [2:0] a, input logic [31:0] d);
        l_req = req; l_we = we; l_lock = lk; l_addr = a; l_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rst = 1'b1;
        cpu(1, 1, 3'd5, 32'hdead);
        ldr(1, 1, 1, 3'd6, 32'hbeef);
        @(negedge clk);
        check("rst_c_gnt", c_gnt, 0);
        check("rst_l_gnt", l_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_stall", c_stall, 0);
        tick;
        @(negedge clk);
        check("rst_rvalid", l_rvalid, 0);
        check("rst_mem5", mem[5], 0);
        rst = 1'b0;
        cpu(0, 0, 0, 0);
        ldr(0, 0, 0, 0, 0);
        tick;

        // loader preload
        ldr(1, 1, 0, 3'd0, 32'd1);
        @(negedge clk);
        check("pre_l_gnt", l_gnt, 1);
        check("pre_we", mem_we, 1);
        tick;
        ldr(1, 1, 0, 3'd1, 32'd2);
        tick;
        ldr(1, 0, 0, 3'd0, 0);
        @(negedge clk);
        check("pre_mem0", mem[0], 1);
        check("pre_mem1", mem[1], 2);
        check("rd_nowe", mem_we, 0);
        tick;
        ldr(1, 0, 0, 3'd1, 0);
        @(negedge clk);
        check("rd0_rvalid", l_rvalid, 1);
        check("rd0_rdata", l_rdata, 1);
        tick;
        ldr(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd1_rvalid", l_rvalid, 1);
        check("rd1_rdata", l_rdata, 2);
        tick;
        @(negedge clk);
        check("rd_done", l_rvalid, 0);

        // CPU store then load
        cpu(1, 1, 3'd2, 32'd7);
        @(negedge clk);
        check("cst_gnt", c_gnt, 1);
        check("cst_stall", c_stall, 0);
        check("cst_sel", mem_sel, 2);
        tick;
        cpu(1, 0, 3'd2, 0);
        @(negedge clk);
        check("cld_rdata", c_rdata, 7);
        check("cld_stall", c_stall, 0);
        tick;
        cpu(0, 0, 0, 0);
        @(negedge clk);
        check("cidle_rdata", c_rdata, 0);
        tick;

        // contention: loader forced in every fifth cycle
        cpu(1, 0, 3'd0, 0);
        ldr(1, 0, 0, 3'd1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("pri_l_gnt%0d", i), l_gnt, i % 5 == 4);
            check($sformatf("pri_c_gnt%0d", i), c_gnt, i % 5 != 4);
            check($sformatf("pri_stall%0d", i), c_stall, i % 5 == 4);
            tick;
        end
        cpu(0, 0, 0, 0);
        ldr(0, 0, 0, 0, 0);
        tick;

        // lock burst: CPU stalls until the loader releases
        ldr(1, 1, 1, 3'd3, 32'h30);
        @(negedge clk);
        check("lk_first", l_gnt, 1);
        tick;
        cpu(1, 0, 3'd3, 0);
        for (int i = 0; i < 3; i++) begin
            ldr(1, 1, i < 2, 3'(4 + i), 32'(8'h40 + i));
            @(negedge clk);
            check($sformatf("lk_stall%0d", i), c_stall, 1);
            check($sformatf("lk_l_gnt%0d", i), l_gnt, 1);
            tick;
        end
        ldr(0, 0, 0, 0, 0);
        @(negedge clk);
        check("lk_c_gnt", c_gnt, 1);
        check("lk_c_rdata", c_rdata, 32'h30);
        check("lk_mem6", mem[6], 32'h42);
        tick;
        cpu(0, 0, 0, 0);
        tick;

        // reset in the middle of a lock
        ldr(1, 1, 1, 3'd7, 32'h77);
        tick;
        cpu(1, 0, 3'd7, 0);
        @(negedge clk);
        check("rl_stall", c_stall, 1);
        tick;
        rst = 1'b1;
        @(negedge clk);
        check("rl_rst_gnt", l_gnt, 0);
        check("rl_rst_we", mem_we, 0);
        check("rl_rst_stall", c_stall, 0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("rl_c_gnt", c_gnt, 1);
        check("rl_l_gnt", l_gnt, 0);
        check("rl_c_rdata", c_rdata, 32'h77);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
